rename_reg_file: RTL and testbench
==================================

// Module: rename_reg_file
// PURPOSE
//  Architectural register file plus rename-tag table (register status) for the out-of-order core.
//  Sits between decoder/issue and the ROB. Decoder looks up NUM_RD source regs per cycle.
//  ROB renames one rd per cycle and retires up to COMMIT_W results per cycle.
//  Successor to the single-commit, 2-read register file. Adds parametrised ports and multi-commit ordering.
//  Adds stall-safe state and an optional branch checkpoint.
// PARAMETERS
//  NUM_REGS   32  architectural registers (power of 2); reg 0 hardwired to zero
//  XLEN       32  data width
//  TAG_W      4   ROB tag width
//  NUM_RD     2   source lookup ports
//  COMMIT_W   2   commit ports per cycle (1..2); higher index = younger
// PORTS  (R = log2(NUM_REGS); bus[k] = slice k)
//  clk_in         in   1              clock, rising edge
//  rst_in         in   1              reset, asynchronous, active-low
//  rdy_in         in   1              0 = hold all state
//  flush_in       in   1              mispredict: clear every busy bit/tag
//  rd_reg_in      in   NUM_RD*R       lookup register ids
//  rd_val_out     out  NUM_RD*XLEN    operand value (reg or ROB-forwarded)
//  rd_dep_out     out  NUM_RD         1 = operand not yet available
//  rd_tag_out     out  NUM_RD*TAG_W   producing ROB tag (valid when busy)
//  rob_q_tag_out  out  NUM_RD*TAG_W   tag queried in ROB (= rd_tag_out)
//  rob_q_rdy_in   in   NUM_RD         ROB entry has result
//  rob_q_val_in   in   NUM_RD*XLEN    ROB entry result
//  ren_valid_in   in   1              rename this cycle
//  ren_reg_in     in   R              rd being renamed
//  ren_tag_in     in   TAG_W          ROB tag assigned
//  cm_valid_in    in   COMMIT_W       commit slot valid
//  cm_reg_in      in   COMMIT_W*R     commit rd
//  cm_tag_in      in   COMMIT_W*TAG_W committing ROB tag
//  cm_val_in      in   COMMIT_W*XLEN  commit value
// BEHAVIOUR
//  Reset (rst_in=0, async): all regs 0, busy 0, tags 0.
//  Lookup outputs are combinational; they have no registered state.
//  Lookup of port p, reg r:
//  - busy_eff = (ren_valid && ren_reg==r && r!=0) || busy[r].
//  - tag = same-cycle rename tag if it matches, else tag[r].
//  - dep = busy_eff && !rob_q_rdy[p].
//  - val = busy_eff ? rob_q_val[p] : reg[r].
//  - r==0 -> val 0, dep 0 always.
//  Commit write (rising edge, rdy_in=1): each valid slot with reg!=0 writes reg[cm_reg] <= cm_val.
//  - Two slots, same reg: slot 1 value wins.
//  - Busy clear: slot clears busy[r] only if tag[r]==cm_tag and no same-cycle rename of r.
//  Rename: ren_valid && ren_reg!=0 -> busy<=1, tag<=ren_tag.
//  - Rename overrides any commit clear on the same reg.
//  flush_in=1: all busy/tag <= 0 and rename is ignored.
//  - Commit value writes in the flush cycle are still performed.
//  Priority: reset > rdy_in=0 (full hold, commits/renames dropped) > flush > rename > commit-clear.
//  Writes/renames to reg 0 are discarded.
// CONFIGURATION
//  RF_CKPT_EN defined: adds ckpt_take_in (1), ckpt_restore_in (1) and a single busy/tag snapshot.
//  - take: snapshot <= next-state table (after this cycle's rename/commit).
//  - commits also clear matching busy bits in the snapshot.
//  - restore: table <= snapshot with this cycle's commit clears applied; same-cycle rename ignored.
//  - flush_in overrides restore. take and restore in the same cycle: restore applies, snapshot retained.
//  RF_CKPT_EN undefined: the ports and the snapshot do not exist; recovery is flush only.
// TESTING
//  1. Reset, then commit x5=0x1234 (tag 3) with nothing busy -> next cycle lookup x5 gives val 0x1234, dep 0.
//  2. Rename x7 tag 2 and look up x7 in the same cycle with rob_q_rdy=0 -> dep 1, tag 2.
//     Next cycle rob_q_rdy=1, val 0xAA -> dep 0, val 0xAA.
//  3. Rename x7 tag 2 then tag 4; commit x7 tag 2 -> reg updated, busy stays 1 with tag 4.
//     Commit tag 4 -> busy 0.
//  4. Dual commit x9 (slot0 0x1, slot1 0x2) plus rename x9 tag 6 in one cycle -> reg 0x2, busy 1, tag 6.
//  5. Rename x3/x4; flush -> busy 0.
//     Separately, rdy_in=0 with commit and rename -> no state change.
//     Write x0=5 -> x0 reads 0.
//  6. (RF_CKPT_EN) Rename x1 t1; take; rename x2 t2; commit x1 t1; restore -> x1 not busy, x2 not busy.

Source files
------------

// File: rtl/rename_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rename_reg_file                                                 |
// | Purpose  : Architectural register file plus rename-tag (register status)   |
// |            table. Combinational operand lookup with ROB forwarding, one    |
// |            rename per cycle, up to COMMIT_W in-order commits per cycle.    |
// | Ports    : clk_in/rst_in (async, active-low)  clock and reset             |
// |            rdy_in          0 = hold all state                             |
// |            flush_in        clear every busy bit and tag                   |
// |            rd_reg_in       lookup register ids (NUM_RD slices)            |
// |            rd_val_out/rd_dep_out/rd_tag_out  operand value/dep/tag        |
// |            rob_q_tag_out   tag queried in the ROB (= rd_tag_out)          |
// |            rob_q_rdy_in/rob_q_val_in         ROB answer per lookup port   |
// |            ren_valid_in/ren_reg_in/ren_tag_in  rename request             |
// |            cm_valid_in/cm_reg_in/cm_tag_in/cm_val_in  commit slots        |
// |            ckpt_take_in/ckpt_restore_in  only when RF_CKPT_EN is defined  |
// | Config   : `define RF_CKPT_EN adds a single busy/tag checkpoint.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rename_reg_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2,
  parameter int COMMIT_W = 2,
  localparam int REG_W   = $clog2(NUM_REGS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic [NUM_RD*REG_W-1:0]   rd_reg_in,
  output logic [NUM_RD*XLEN-1:0]    rd_val_out,
  output logic [NUM_RD-1:0]         rd_dep_out,
  output logic [NUM_RD*TAG_W-1:0]   rd_tag_out,
  output logic [NUM_RD*TAG_W-1:0]   rob_q_tag_out,
  input  logic [NUM_RD-1:0]         rob_q_rdy_in,
  input  logic [NUM_RD*XLEN-1:0]    rob_q_val_in,
  input  logic                      ren_valid_in,
  input  logic [REG_W-1:0]          ren_reg_in,
  input  logic [TAG_W-1:0]          ren_tag_in,
  input  logic [COMMIT_W-1:0]       cm_valid_in,
  input  logic [COMMIT_W*REG_W-1:0] cm_reg_in,
  input  logic [COMMIT_W*TAG_W-1:0] cm_tag_in,
  input  logic [COMMIT_W*XLEN-1:0]  cm_val_in
`ifdef RF_CKPT_EN
  ,
  input  logic                      ckpt_take_in,
  input  logic                      ckpt_restore_in
`endif
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_d  [NUM_REGS];

`ifdef RF_CKPT_EN
  logic [NUM_REGS-1:0] snap_busy_q, snap_busy_d;
  logic [TAG_W-1:0]    snap_tag_q [NUM_REGS];
  logic [TAG_W-1:0]    snap_tag_d [NUM_REGS];
`endif

  logic w_ren_ok;
  assign w_ren_ok = ren_valid_in && (ren_reg_in != '0);

  // Operand lookup: a same-cycle rename of the looked-up register takes
  // precedence over the table so the consumer sees the newest producer.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
    logic [REG_W-1:0] w_reg;
    logic             w_hit;
    logic             w_busy;
    logic [TAG_W-1:0] w_tag;

    assign w_reg  = rd_reg_in[p*REG_W +: REG_W];
    assign w_hit  = w_ren_ok && (ren_reg_in == w_reg);
    assign w_busy = w_hit || busy_q[w_reg];
    assign w_tag  = w_hit ? ren_tag_in : tag_q[w_reg];

    assign rd_tag_out[p*TAG_W +: TAG_W]    = w_tag;
    assign rob_q_tag_out[p*TAG_W +: TAG_W] = w_tag;
    assign rd_dep_out[p] = (w_reg != '0) && w_busy && !rob_q_rdy_in[p];
    assign rd_val_out[p*XLEN +: XLEN] =
        (w_reg == '0) ? '0 :
        w_busy        ? rob_q_val_in[p*XLEN +: XLEN] : regs_q[w_reg];
  end

  // Next-state table. Commit slots are walked oldest first so a younger slot
  // writing the same register overwrites the older value.
  always_comb begin
    logic [REG_W-1:0] r;
    logic [TAG_W-1:0] t;
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
`ifdef RF_CKPT_EN
    snap_busy_d = snap_busy_q;
    snap_tag_d  = snap_tag_q;
`endif
    for (int s = 0; s < COMMIT_W; s++) begin
      r = cm_reg_in[s*REG_W +: REG_W];
      t = cm_tag_in[s*TAG_W +: TAG_W];
      if (cm_valid_in[s] && (r != '0)) begin
        regs_d[r] = cm_val_in[s*XLEN +: XLEN];
        // Only the producer currently named in the table may release it.
        if (tag_q[r] == t) busy_d[r] = 1'b0;
`ifdef RF_CKPT_EN
        if (snap_tag_q[r] == t) snap_busy_d[r] = 1'b0;
`endif
      end
    end

    if (flush_in) begin
      busy_d = '0;
      for (int i = 0; i < NUM_REGS; i++) tag_d[i] = '0;
    end
`ifdef RF_CKPT_EN
    else if (ckpt_restore_in) begin
      busy_d = snap_busy_d;
      tag_d  = snap_tag_q;
    end
`endif
    else if (w_ren_ok) begin
      // Applied after the commit clears so a rename always wins.
      busy_d[ren_reg_in] = 1'b1;
      tag_d[ren_reg_in]  = ren_tag_in;
    end

`ifdef RF_CKPT_EN
    // An effective restore keeps the (commit-cleaned) snapshot.
    if (ckpt_take_in && !(ckpt_restore_in && !flush_in)) begin
      snap_busy_d = busy_d;
      snap_tag_d  = tag_d;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
`ifdef RF_CKPT_EN
      snap_busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) snap_tag_q[i] <= '0;
`endif
    end else if (rdy_in) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
`ifdef RF_CKPT_EN
      snap_busy_q <= snap_busy_d;
      snap_tag_q  <= snap_tag_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rename_reg_file                                              |
// | Purpose  : Self-checking bench for rename_reg_file: directed scenarios     |
// |            with literal expectations, then randomized traffic compared    |
// |            every cycle against a behavioural register/status model.       |
// | Config   : RF_CKPT_EN adds checkpoint stimulus and model.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rename_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy, flush;
  logic [9:0]  rd_reg;
  logic [63:0] rd_val;
  logic [1:0]  rd_dep;
  logic [7:0]  rd_tag, rob_tag;
  logic [1:0]  rob_rdy;
  logic [63:0] rob_val;
  logic        ren_v;
  logic [4:0]  ren_reg;
  logic [3:0]  ren_tag;
  logic [1:0]  cm_v;
  logic [9:0]  cm_reg;
  logic [7:0]  cm_tag;
  logic [63:0] cm_val;
  logic        take, restore;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_reg_file dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .rd_reg_in(rd_reg), .rd_val_out(rd_val), .rd_dep_out(rd_dep),
    .rd_tag_out(rd_tag), .rob_q_tag_out(rob_tag),
    .rob_q_rdy_in(rob_rdy), .rob_q_val_in(rob_val),
    .ren_valid_in(ren_v), .ren_reg_in(ren_reg), .ren_tag_in(ren_tag),
    .cm_valid_in(cm_v), .cm_reg_in(cm_reg), .cm_tag_in(cm_tag), .cm_val_in(cm_val)
`ifdef RF_CKPT_EN
    , .ckpt_take_in(take), .ckpt_restore_in(restore)
`endif
  );

  // Behavioural model: what the architecture says the table holds.
  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];
  bit          s_busy [32];
  logic [3:0]  s_tag  [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 0; m_busy[i] = 0; m_tag[i] = 0; s_busy[i] = 0; s_tag[i] = 0;
    end
  endtask

  task automatic model_step();
    bit         clr [32];
    bit         sclr[32];
    bit         do_restore, do_take;
    logic [4:0] r;
    for (int i = 0; i < 32; i++) begin clr[i] = 0; sclr[i] = 0; end
    for (int s = 0; s < 2; s++) begin
      r = cm_reg[s*5 +: 5];
      if (cm_v[s] && r != 0) begin
        m_reg[r] = cm_val[s*32 +: 32];
        if (m_tag[r] == cm_tag[s*4 +: 4]) clr[r] = 1;
        if (s_tag[r] == cm_tag[s*4 +: 4]) sclr[r] = 1;
      end
    end
`ifdef RF_CKPT_EN
    do_restore = restore && !flush;
    do_take    = take && !do_restore;
`else
    do_restore = 0;
    do_take    = 0;
`endif
    for (int i = 0; i < 32; i++) if (sclr[i]) s_busy[i] = 0;
    if (flush) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
    end else if (do_restore) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = s_busy[i]; m_tag[i] = s_tag[i]; end
    end else begin
      for (int i = 0; i < 32; i++) if (clr[i]) m_busy[i] = 0;
      if (ren_v && ren_reg != 0) begin m_busy[ren_reg] = 1; m_tag[ren_reg] = ren_tag; end
    end
    if (do_take)
      for (int i = 0; i < 32; i++) begin s_busy[i] = m_busy[i]; s_tag[i] = m_tag[i]; end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (rdy) model_step();
  end

  // Per-cycle comparison of every lookup port against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        logic [4:0]  r;
        bit          hit, be, edep;
        logic [3:0]  etag;
        logic [31:0] evl;
        r    = rd_reg[p*5 +: 5];
        hit  = ren_v && ren_reg == r && r != 0;
        be   = hit || m_busy[r];
        etag = hit ? ren_tag : m_tag[r];
        edep = (r != 0) && be && !rob_rdy[p];
        evl  = (r == 0) ? 32'h0 : (be ? rob_val[p*32 +: 32] : m_reg[r]);
        checks++;
        if (rd_val[p*32 +: 32] !== evl) begin
          errors++;
          $display("FAIL model_val port%0d x%0d got %h expected %h", p, r, rd_val[p*32 +: 32], evl);
        end
        checks++;
        if (rd_dep[p] !== edep) begin
          errors++;
          $display("FAIL model_dep port%0d x%0d got %0b expected %0b", p, r, rd_dep[p], edep);
        end
        if (be) begin
          checks++;
          if (rd_tag[p*4 +: 4] !== etag || rob_tag[p*4 +: 4] !== etag) begin
            errors++;
            $display("FAIL model_tag port%0d x%0d got %h/%h expected %h", p, r,
                     rd_tag[p*4 +: 4], rob_tag[p*4 +: 4], etag);
          end
        end
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    rdy = 1; flush = 0; rd_reg = 0; rob_rdy = 0; rob_val = 0;
    ren_v = 0; ren_reg = 0; ren_tag = 0;
    cm_v = 0; cm_reg = 0; cm_tag = 0; cm_val = 0;
    take = 0; restore = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic commit(input int s, input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    cm_v[s] = 1; cm_reg[s*5 +: 5] = r; cm_tag[s*4 +: 4] = t; cm_val[s*32 +: 32] = v;
  endtask

  task automatic rename(input logic [4:0] r, input logic [3:0] t);
    ren_v = 1; ren_reg = r; ren_tag = t;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle();
    logic [4:0] r;
    rdy   = ($urandom_range(0, 9) != 0);
    flush = ($urandom_range(0, 29) == 0);
    ren_v = ($urandom_range(0, 9) < 6);
    ren_reg = pick_reg();
    ren_tag = 4'($urandom);
    for (int s = 0; s < 2; s++) begin
      r = pick_reg();
      cm_v[s] = 1'($urandom_range(0, 1));
      cm_reg[s*5 +: 5] = r;
      cm_tag[s*4 +: 4] = ($urandom_range(0, 1) == 1) ? m_tag[r] : 4'($urandom);
      cm_val[s*32 +: 32] = $urandom;
    end
    for (int p = 0; p < 2; p++) begin
      rd_reg[p*5 +: 5] = pick_reg();
      rob_rdy[p] = 1'($urandom_range(0, 1));
      rob_val[p*32 +: 32] = $urandom;
    end
    take    = ($urandom_range(0, 19) == 0);
    restore = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    rd_reg = {5'd5, 5'd31};
    @(negedge clk);
    lit("reset_val", rd_val[31:0], 32'h0);
    lit("reset_dep", {30'd0, rd_dep}, 32'h0);

    // 1: commit with nothing busy
    next_cycle(); commit(0, 5'd5, 4'd3, 32'h1234);
    next_cycle(); rd_reg[4:0] = 5'd5;
    @(negedge clk);
    lit("t1_val", rd_val[31:0], 32'h1234);
    lit("t1_dep", {31'd0, rd_dep[0]}, 32'h0);

    // 2: same-cycle rename forwarding, then ROB-ready forwarding
    next_cycle(); rename(5'd7, 4'd2); rd_reg[4:0] = 5'd7;
    @(negedge clk);
    lit("t2_dep", {31'd0, rd_dep[0]}, 32'h1);
    lit("t2_tag", {28'd0, rd_tag[3:0]}, 32'h2);
    next_cycle(); rd_reg[4:0] = 5'd7; rob_rdy = 2'b01; rob_val[31:0] = 32'hAA;
    @(negedge clk);
    lit("t2_fwd_dep", {31'd0, rd_dep[0]}, 32'h0);
    lit("t2_fwd_val", rd_val[31:0], 32'hAA);

    // 3: stale commit does not release a re-renamed register
    next_cycle(); rename(5'd7, 4'd4);
    next_cycle(); commit(0, 5'd7, 4'd2, 32'h77);
    next_cycle(); rd_reg[4:0] = 5'd7; commit(0, 5'd7, 4'd4, 32'h88);
    @(negedge clk);
    lit("t3_dep", {31'd0, rd_dep[0]}, 32'h1);
    lit("t3_tag", {28'd0, rd_tag[3:0]}, 32'h4);
    next_cycle(); rd_reg[4:0] = 5'd7;
    @(negedge clk);
    lit("t3_free_dep", {31'd0, rd_dep[0]}, 32'h0);
    lit("t3_free_val", rd_val[31:0], 32'h88);

    // 4: dual commit to one register plus rename of it
    next_cycle(); commit(0, 5'd9, 4'd0, 32'h1); commit(1, 5'd9, 4'd0, 32'h2); rename(5'd9, 4'd6);
    next_cycle(); rd_reg[4:0] = 5'd9;
    @(negedge clk);
    lit("t4_dep", {31'd0, rd_dep[0]}, 32'h1);
    lit("t4_tag", {28'd0, rd_tag[3:0]}, 32'h6);
    flush = 1;
    next_cycle(); rd_reg[4:0] = 5'd9;
    @(negedge clk);
    lit("t4_val", rd_val[31:0], 32'h2);

    // 5: flush, hold, and x0
    next_cycle(); rename(5'd3, 4'd1);
    next_cycle(); rename(5'd4, 4'd5);
    next_cycle(); flush = 1;
    next_cycle(); rd_reg = {5'd4, 5'd3};
    @(negedge clk);
    lit("t5_flush_dep", {30'd0, rd_dep}, 32'h0);
    next_cycle(); rdy = 0; commit(0, 5'd10, 4'd0, 32'h55); rename(5'd11, 4'd7);
    next_cycle(); rd_reg = {5'd11, 5'd10};
    @(negedge clk);
    lit("t5_hold_val", rd_val[31:0], 32'h0);
    lit("t5_hold_dep", {30'd0, rd_dep}, 32'h0);
    next_cycle(); commit(0, 5'd0, 4'd0, 32'h5); rename(5'd0, 4'd3);
    rd_reg = {5'd0, 5'd0};
    @(negedge clk);
    lit("t5_x0_dep", {30'd0, rd_dep}, 32'h0);
    next_cycle(); rd_reg = {5'd0, 5'd0}; rob_val = {32'hFFFF, 32'hFFFF};
    @(negedge clk);
    lit("t5_x0_val", rd_val[31:0], 32'h0);

`ifdef RF_CKPT_EN
    // 6: checkpoint take / commit-clean / restore
    next_cycle(); flush = 1;
    next_cycle(); rename(5'd1, 4'd1);
    next_cycle(); take = 1;
    next_cycle(); rename(5'd2, 4'd2);
    next_cycle(); commit(0, 5'd1, 4'd1, 32'h11);
    next_cycle(); restore = 1;
    next_cycle(); rd_reg = {5'd2, 5'd1};
    @(negedge clk);
    lit("t6_dep", {30'd0, rd_dep}, 32'h0);
    lit("t6_val", rd_val[31:0], 32'h11);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rand_cycle();
    end
    next_cycle();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
